pc_update_unit: RTL and testbench

- PC register stage directly downstream of the PC-source mux in the multicycle MIPS datapath.
- Registers the mux output under PCWrite, or under PCWriteCond gated by the evaluated branch condition.
- Detects misaligned targets and captures EPC.
- Raises a misalign exception request to the control unit with a req/ack handshake.

---
 rtl/pc_update_unit_pkg.sv | 22 ++
 rtl/branch_cond_eval.sv | 22 ++
 rtl/pc_update_unit.sv | 118 +++++++++++
 tb/tb_pc_update_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_update_unit_pkg.sv
// rtl/pc_update_unit_pkg.sv - shared encodings and defaults for the PC update stage
package pc_update_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BR_BEQ = 2'b00,
        BR_BNE = 2'b01,
        BR_BLE = 2'b10,
        BR_BGT = 2'b11
    } branch_op_e;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_EXC_PEND = 1'b1
    } pc_state_e;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition from ALU flags
module branch_cond_eval
    import pc_update_unit_pkg::*;
(
    input  logic [1:0] branch_op,
    input  logic       alu_zero,
    input  logic       alu_gt,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (branch_op_e'(branch_op))
            BR_BEQ:  cond = alu_zero;
            BR_BNE:  cond = !alu_zero;
            BR_BLE:  cond = alu_zero | !alu_gt;
            BR_BGT:  cond = alu_gt & !alu_zero;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_update_unit.sv
// rtl/pc_update_unit.sv - PC register with branch gating, EPC capture and misalign req/ack
// Optional committed-update counter enabled by PC_UPDATE_COUNT_EN.
module pc_update_unit
    import pc_update_unit_pkg::*;
#(
    parameter int unsigned          WIDTH      = 32,
    parameter logic [WIDTH-1:0]     RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned          EPC_OFFSET = 4
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pc_next,
    input  logic             pc_write,
    input  logic             pc_write_cond,
    input  logic [1:0]       branch_op,
    input  logic             alu_zero,
    input  logic             alu_gt,
    input  logic             epc_write,
    input  logic             exc_ack,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] epc,
    output logic             branch_taken,
    output logic             misalign_req,
    output logic [WIDTH-1:0] pc_wr_count
);

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             req_q, req_d;
    logic             cond;
    logic             upd;
    logic             pc_commit;
    logic [WIDTH-1:0] epc_capture;

    branch_cond_eval u_cond (
        .branch_op (branch_op),
        .alu_zero  (alu_zero),
        .alu_gt    (alu_gt),
        .cond      (cond)
    );

    assign branch_taken = pc_write_cond & cond;
    assign upd          = pc_write | branch_taken;
    // The fetch stage has already advanced pc, so the faulting address is one word back.
    assign epc_capture  = pc_q - WIDTH'(EPC_OFFSET);

    always_comb begin
        state_d   = state_q;
        epc_d     = epc_q;
        req_d     = req_q;
        pc_commit = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (upd && !word_aligned(pc_next[1:0])) begin
                    epc_d   = epc_capture;
                    req_d   = 1'b1;
                    state_d = ST_EXC_PEND;
                end else begin
                    if (epc_write) begin
                        epc_d = epc_capture;
                    end
                    pc_commit = upd;
                end
            end
            ST_EXC_PEND: begin
                // Updates are dropped until the control unit acknowledges, including the ack cycle.
                req_d = 1'b1;
                if (exc_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_RUN;
            end
        endcase
    end

    assign pc_d = pc_commit ? pc_next : pc_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            req_q   <= req_d;
        end
    end

`ifdef PC_UPDATE_COUNT_EN
    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (pc_commit) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign pc_wr_count = cnt_q;
`else
    assign pc_wr_count = '0;
`endif

    assign pc           = pc_q;
    assign epc          = epc_q;
    assign misalign_req = req_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// tb/tb_pc_update_unit.sv - self-checking bench for pc_update_unit against a behavioural model
module tb_pc_update_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_next;
    logic        pc_write, pc_write_cond, alu_zero, alu_gt, epc_write, exc_ack;
    logic [1:0]  branch_op;
    logic [31:0] pc, epc, pc_wr_count;
    logic        branch_taken, misalign_req;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc, m_epc, m_cnt;
    logic        m_req;

    pc_update_unit dut (
        .clk           (clk),
        .reset         (reset),
        .pc_next       (pc_next),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_op     (branch_op),
        .alu_zero      (alu_zero),
        .alu_gt        (alu_gt),
        .epc_write     (epc_write),
        .exc_ack       (exc_ack),
        .pc            (pc),
        .epc           (epc),
        .branch_taken  (branch_taken),
        .misalign_req  (misalign_req),
        .pc_wr_count   (pc_wr_count)
    );

    always #5 clk = ~clk;

    function automatic logic cond_of(input logic [1:0] op, input logic z, input logic g);
        case (op)
            2'd0:    return z;
            2'd1:    return !z;
            2'd2:    return z || !g;
            default: return g && !z;
        endcase
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef PC_UPDATE_COUNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    // Advance one clock, applying the architectural rules to the model with the inputs held at the edge.
    task automatic tick();
        logic u;
        @(posedge clk);
        u = pc_write || (pc_write_cond && cond_of(branch_op, alu_zero, alu_gt));
        if (!reset) begin
            m_pc = RST_PC; m_epc = 0; m_req = 0; m_cnt = 0;
        end else if (m_req) begin
            if (exc_ack) m_req = 0;
        end else if (u && pc_next[1:0] != 2'b00) begin
            m_epc = m_pc - 32'd4;
            m_req = 1;
        end else begin
            if (epc_write) m_epc = m_pc - 32'd4;
            if (u) begin
                m_pc  = pc_next;
                m_cnt = m_cnt + 32'd1;
            end
        end
        #1;
    endtask

    task automatic idle();
        pc_write = 0; pc_write_cond = 0; epc_write = 0; exc_ack = 0;
        branch_op = 2'd0; alu_zero = 0; alu_gt = 0; pc_next = 32'h0;
    endtask

    task automatic test_reset();
        idle();
        reset = 0;
        tick(); tick();
        checks++; if (pc !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
        checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want 0", epc); end
        checks++; if (misalign_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", misalign_req); end
        checks++; if (pc_wr_count !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", pc_wr_count); end
        reset = 1;
    endtask

    task automatic test_epc_wrap();
        idle();
        epc_write = 1;
        tick();
        epc_write = 0;
        checks++; if (epc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL epc_wrap: got %h want fffffffc", epc); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL epc_wrap_pc: got %h want 0", pc); end
    endtask

    task automatic test_aligned_write();
        idle();
        pc_write = 1; pc_next = 32'h4;
        tick();
        pc_write = 0;
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL write_pc: got %h want 4", pc); end
        checks++; if (pc_wr_count !== exp_cnt()) begin errors++; $display("FAIL write_cnt: got %h want %h", pc_wr_count, exp_cnt()); end
`ifdef PC_UPDATE_COUNT_EN
        checks++; if (pc_wr_count !== 32'd1) begin errors++; $display("FAIL write_cnt1: got %h want 1", pc_wr_count); end
`endif
    endtask

    task automatic test_cond_branch();
        idle();
        pc_write_cond = 1; branch_op = 2'b01; alu_zero = 1; pc_next = 32'h40;
        #1;
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL bne_nt_taken: got %b want 0", branch_taken); end
        tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL bne_nt_pc: got %h want 4", pc); end
        alu_zero = 0;
        #1;
        checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL bne_t_taken: got %b want 1", branch_taken); end
        tick();
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL bne_t_pc: got %h want 40", pc); end
        branch_op = 2'b10; alu_zero = 0; alu_gt = 0;
        #1;
        checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL ble_taken: got %b want 1", branch_taken); end
        branch_op = 2'b11; alu_zero = 1; alu_gt = 1;
        #1;
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL bgt_taken: got %b want 0", branch_taken); end
        idle();
        tick();
    endtask

    task automatic test_epc_with_update();
        idle();
        epc_write = 1; pc_write = 1; pc_next = 32'h100;
        tick();
        idle();
        checks++; if (epc !== 32'h3C) begin errors++; $display("FAIL epc_upd_epc: got %h want 3c", epc); end
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL epc_upd_pc: got %h want 100", pc); end
    endtask

    task automatic test_misalign();
        idle();
        pc_write = 1; pc_next = 32'h202;
        tick();
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL mis_pc: got %h want 100", pc); end
        checks++; if (epc !== 32'hFC) begin errors++; $display("FAIL mis_epc: got %h want fc", epc); end
        checks++; if (misalign_req !== 1'b1) begin errors++; $display("FAIL mis_req: got %b want 1", misalign_req); end
        pc_next = 32'h300; epc_write = 1;
        tick(); tick();
        checks++; if (pc !== 32'h100 || epc !== 32'hFC) begin errors++; $display("FAIL mis_frozen: got pc %h epc %h want 100 fc", pc, epc); end
        checks++; if (misalign_req !== 1'b1) begin errors++; $display("FAIL mis_hold: got %b want 1", misalign_req); end
        exc_ack = 1;
        tick();
        exc_ack = 0; epc_write = 0;
        checks++; if (misalign_req !== 1'b0) begin errors++; $display("FAIL mis_ack_req: got %b want 0", misalign_req); end
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL mis_ack_pc: got %h want 100", pc); end
        tick();
        checks++; if (pc !== 32'h300) begin errors++; $display("FAIL mis_handler_pc: got %h want 300", pc); end
        idle();
    endtask

    task automatic test_reset_in_exc();
        idle();
        pc_write = 1; pc_next = 32'h301;
        tick();
        idle();
        checks++; if (misalign_req !== 1'b1) begin errors++; $display("FAIL rexc_req_set: got %b want 1", misalign_req); end
        reset = 0;
        tick();
        reset = 1;
        checks++; if (pc !== RST_PC || epc !== 32'h0 || misalign_req !== 1'b0) begin
            errors++; $display("FAIL rexc_state: got pc %h epc %h req %b want %h 0 0", pc, epc, misalign_req, RST_PC);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        pc_write = 1;
        for (int i = 1; i <= 8; i++) begin
            pc_next = 32'(i) * 32'h10;
            tick();
            checks++; if (pc !== m_pc || pc !== 32'(i) * 32'h10) begin errors++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, pc, m_pc); end
        end
        checks++; if (pc_wr_count !== exp_cnt()) begin errors++; $display("FAIL b2b_cnt: got %h want %h", pc_wr_count, exp_cnt()); end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 49) != 0);
            pc_write      = ($urandom_range(0, 3) == 0);
            pc_write_cond = ($urandom_range(0, 2) == 0);
            branch_op     = 2'($urandom_range(0, 3));
            alu_zero      = 1'($urandom_range(0, 1));
            alu_gt        = 1'($urandom_range(0, 1));
            epc_write     = ($urandom_range(0, 4) == 0);
            exc_ack       = ($urandom_range(0, 2) == 0);
            pc_next       = $urandom();
            if ($urandom_range(0, 3) != 0) pc_next[1:0] = 2'b00;
            #1;
            checks++;
            if (branch_taken !== (pc_write_cond && cond_of(branch_op, alu_zero, alu_gt))) begin
                errors++; $display("FAIL rnd_taken[%0d]: got %b want %b", i, branch_taken, pc_write_cond && cond_of(branch_op, alu_zero, alu_gt));
            end
            tick();
            checks++;
            if (pc !== m_pc || epc !== m_epc || misalign_req !== m_req || pc_wr_count !== exp_cnt()) begin
                errors++;
                $display("FAIL rnd_state[%0d]: got pc %h epc %h req %b cnt %h want %h %h %b %h",
                         i, pc, epc, misalign_req, pc_wr_count, m_pc, m_epc, m_req, exp_cnt());
            end
        end
        reset = 1;
        idle();
    endtask

    initial begin
        m_pc = 0; m_epc = 0; m_req = 0; m_cnt = 0;
        reset = 0;
        idle();
        test_reset();
        test_epc_wrap();
        test_aligned_write();
        test_cond_branch();
        test_epc_with_update();
        test_misalign();
        test_reset_in_exc();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
